// File: rtl/csr_pkg.sv
// Shared definitions for csr_file_m: CSR addresses, WARL write masks,
// operation encoding, interrupt causes and mstatus bit positions.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [31:0] MSTATUS_WMASK   = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MPP     = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK       = 32'h0000_0888;
    localparam logic [31:0] MCOUNTINH_WMASK = 32'h0000_0005;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    function automatic logic [31:0] csr_rmw(input csr_op_e op, input logic [31:0] old_v,
                                            input logic [31:0] wdata);
        case (op)
            CSR_RW:  return wdata;
            CSR_RS:  return old_v | wdata;
            CSR_RC:  return old_v & ~wdata;
            default: return old_v;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter split into two 32-bit halves; a write to one half
// overrides only that half's update, the other half still takes the carry.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        inhibit_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [31:0] lo_q, lo_d, hi_q, hi_d;
    logic        step, carry;

    always_comb begin
        step  = inc_i & ~inhibit_i;
        carry = step & (lo_q == 32'hFFFF_FFFF);
        lo_d  = wr_lo_i ? wdata_i : lo_q + {31'b0, step};
        hi_d  = wr_hi_i ? wdata_i : hi_q + {31'b0, carry};
    end

    // NOTE: non-blocking assignments so both halves sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: atomic CSRRW/RS/RC, WARL masking, trap/mret stacking,
// 64-bit counters and a registered interrupt request. Optional HPM counters: CSR_HPM_COUNTER_EN.
module csr_file_m
    import csr_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MHARTID   = 32'h0000_0000,
    parameter int          NUM_HPM   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        csr_op_i,
    input  logic [11:0]       csr_addr_i,
    input  logic [XLEN-1:0]   csr_wdata_i,
    output logic [XLEN-1:0]   csr_rdata_o,
    output logic              csr_illegal_o,
    input  logic              retire_i,
    input  logic              trap_i,
    input  logic [XLEN-1:0]   trap_cause_i,
    input  logic [XLEN-1:0]   trap_epc_i,
    input  logic              mret_i,
    input  logic              irq_ext_i,
    input  logic              irq_timer_i,
    input  logic              irq_soft_i,
    input  logic [NUM_HPM-1:0] hpm_event_i,
    output logic [XLEN-1:0]   mtvec_o,
    output logic [XLEN-1:0]   mepc_o,
    output logic [XLEN-1:0]   mstatus_o,
    output logic              irq_req_o,
    output logic [XLEN-1:0]   irq_cause_o
);

    csr_op_e         op;
    logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mcountinh_q, mcountinh_d, irq_cause_q, irq_cause_d;
    logic            irq_req_q, irq_req_d;
    logic [XLEN-1:0] mip, pend, rdata, wnew, hpm_rdata;
    logic [63:0]     mcycle, minstret;
    logic [4:0]      hpm_idx;
    logic            known, read_only, wants_write, illegal, do_write, hpm_slot, sys_free;

    assign op      = csr_op_e'(csr_op_i);
    assign hpm_idx = csr_addr_i[4:0];

`ifdef CSR_HPM_COUNTER_EN
    localparam bit          HPM_EN    = 1'b1;
    localparam logic [31:0] MCIH_MASK = MCOUNTINH_WMASK | (32'((1 << NUM_HPM) - 1) << 3);
    logic [63:0] hpm_cnt [NUM_HPM];

    for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
        csr_counter64 u_hpm (
            .clk      (clk),
            .rst      (rst),
            .inc_i    (hpm_event_i[gi]),
            .inhibit_i(mcountinh_q[3+gi]),
            .wr_lo_i  (do_write && (csr_addr_i == CSR_MHPMCOUNTER3 + 12'(gi))),
            .wr_hi_i  (do_write && (csr_addr_i == CSR_MHPMCOUNTER3H + 12'(gi))),
            .wdata_i  (wnew),
            .count_o  (hpm_cnt[gi])
        );
    end

    always_comb begin
        hpm_rdata = '0;
        for (int i = 0; i < NUM_HPM; i++)
            if (hpm_idx == 5'(3 + i))
                hpm_rdata = csr_addr_i[7] ? hpm_cnt[i][63:32] : hpm_cnt[i][31:0];
    end
`else
    localparam bit          HPM_EN    = 1'b0;
    localparam logic [31:0] MCIH_MASK = MCOUNTINH_WMASK;
    logic unused_hpm;
    assign unused_hpm = ^hpm_event_i;
    assign hpm_rdata  = '0;
`endif

    always_comb begin
        mip     = '0;
        mip[11] = irq_ext_i;
        mip[7]  = irq_timer_i;
        mip[3]  = irq_soft_i;
    end

    // The whole 0xB00/0xB80/0xC00/0xC80 blocks above index 2 belong to the HPM range.
    assign hpm_slot = (csr_addr_i[11:5] inside {7'h58, 7'h5C, 7'h60, 7'h64}) && (hpm_idx >= 5'd3);

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        rdata     = '0;
        known     = 1'b1;
        read_only = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:       rdata = mstatus_q;
            CSR_MIE:           rdata = mie_q;
            CSR_MTVEC:         rdata = mtvec_q;
            CSR_MCOUNTINHIBIT: rdata = mcountinh_q;
            CSR_MSCRATCH:      rdata = mscratch_q;
            CSR_MEPC:          rdata = mepc_q;
            CSR_MCAUSE:        rdata = mcause_q;
            CSR_MCYCLE:        rdata = mcycle[31:0];
            CSR_MCYCLEH:       rdata = mcycle[63:32];
            CSR_MINSTRET:      rdata = minstret[31:0];
            CSR_MINSTRETH:     rdata = minstret[63:32];
            CSR_MIP:      begin rdata = mip;             read_only = 1'b1; end
            CSR_CYCLE:    begin rdata = mcycle[31:0];    read_only = 1'b1; end
            CSR_CYCLEH:   begin rdata = mcycle[63:32];   read_only = 1'b1; end
            CSR_INSTRET:  begin rdata = minstret[31:0];  read_only = 1'b1; end
            CSR_INSTRETH: begin rdata = minstret[63:32]; read_only = 1'b1; end
            CSR_MHARTID:  begin rdata = MHARTID;         read_only = 1'b1; end
            default: begin
                if (hpm_slot) begin
                    rdata     = hpm_rdata;
                    read_only = HPM_EN & csr_addr_i[10];
                end else begin
                    known = 1'b0;
                end
            end
        endcase

        // RS/RC with a zero mask are pure reads and never count as writes.
        wants_write = (op == CSR_RW) || ((op != CSR_NONE) && (csr_wdata_i != '0));
        illegal     = (op != CSR_NONE) && (!known || (read_only && wants_write));
        do_write    = wants_write && !illegal;
        wnew        = csr_rmw(op, rdata, csr_wdata_i);
    end

    always_comb begin
        mstatus_d   = mstatus_q;
        mie_d       = mie_q;
        mtvec_d     = mtvec_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mscratch_d  = mscratch_q;
        mcountinh_d = mcountinh_q;
        sys_free    = !(trap_i || mret_i);

        if (do_write) begin
            case (csr_addr_i)
                CSR_MSTATUS:       if (sys_free) mstatus_d = (wnew & MSTATUS_WMASK) | MSTATUS_MPP;
                CSR_MIE:           mie_d = wnew & MIE_WMASK;
                CSR_MTVEC:         mtvec_d = {wnew[31:2], wnew[1] ? mtvec_q[1:0] : wnew[1:0]};
                CSR_MEPC:          if (sys_free) mepc_d = {wnew[31:2], 2'b00};
                CSR_MCAUSE:        if (sys_free) mcause_d = wnew;
                CSR_MSCRATCH:      mscratch_d = wnew;
                CSR_MCOUNTINHIBIT: mcountinh_d = wnew & MCIH_MASK;
                default: ;
            endcase
        end

        if (trap_i) begin
            mepc_d                      = trap_epc_i & ~32'h3;
            mcause_d                    = trap_cause_i;
            mstatus_d[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
            mstatus_d[MSTATUS_MIE_BIT]  = 1'b0;
        end else if (mret_i) begin
            mstatus_d[MSTATUS_MIE_BIT]  = mstatus_q[MSTATUS_MPIE_BIT];
            mstatus_d[MSTATUS_MPIE_BIT] = 1'b1;
        end

        pend        = mie_q & mip;
        irq_req_d   = mstatus_q[MSTATUS_MIE_BIT] & (|pend);
        irq_cause_d = pend[11] ? CAUSE_MEI :
                      pend[3]  ? CAUSE_MSI :
                      pend[7]  ? CAUSE_MTI : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q   <= MSTATUS_MPP;
            mie_q       <= '0;
            mtvec_q     <= MTVEC_RST;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mscratch_q  <= '0;
            mcountinh_q <= '0;
            irq_req_q   <= 1'b0;
            irq_cause_q <= '0;
        end else begin
            mstatus_q   <= mstatus_d;
            mie_q       <= mie_d;
            mtvec_q     <= mtvec_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mscratch_q  <= mscratch_d;
            mcountinh_q <= mcountinh_d;
            irq_req_q   <= irq_req_d;
            irq_cause_q <= irq_cause_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (1'b1),
        .inhibit_i(mcountinh_q[0]),
        .wr_lo_i  (do_write && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi_i  (do_write && (csr_addr_i == CSR_MCYCLEH)),
        .wdata_i  (wnew),
        .count_o  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (retire_i),
        .inhibit_i(mcountinh_q[2]),
        .wr_lo_i  (do_write && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi_i  (do_write && (csr_addr_i == CSR_MINSTRETH)),
        .wdata_i  (wnew),
        .count_o  (minstret)
    );

    assign csr_rdata_o   = rdata;
    assign csr_illegal_o = illegal;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign mstatus_o     = mstatus_q;
    assign irq_req_o     = irq_req_q;
    assign irq_cause_o   = irq_cause_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Directed bench for csr_file_m: expected values are queued when stimulus is
// driven and popped when the matching DUT output is sampled.
module tb_csr_file_m;

    localparam logic [31:0] TB_MTVEC   = 32'h0000_0100;
    localparam logic [31:0] TB_HARTID  = 32'h0000_0005;
    localparam int          TB_NUM_HPM = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            csr_op_i;
    logic [11:0]           csr_addr_i;
    logic [31:0]           csr_wdata_i;
    logic [31:0]           csr_rdata_o;
    logic                  csr_illegal_o;
    logic                  retire_i, trap_i, mret_i;
    logic [31:0]           trap_cause_i, trap_epc_i;
    logic                  irq_ext_i, irq_timer_i, irq_soft_i;
    logic [TB_NUM_HPM-1:0] hpm_event_i;
    logic [31:0]           mtvec_o, mepc_o, mstatus_o, irq_cause_o;
    logic                  irq_req_o;

    int          checks = 0;
    int          errors = 0;
    string       exp_tag[$];
    logic [31:0] exp_val[$];

    csr_file_m #(
        .XLEN     (32),
        .MTVEC_RST(TB_MTVEC),
        .MHARTID  (TB_HARTID),
        .NUM_HPM  (TB_NUM_HPM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_op_i     (csr_op_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_illegal_o(csr_illegal_o),
        .retire_i     (retire_i),
        .trap_i       (trap_i),
        .trap_cause_i (trap_cause_i),
        .trap_epc_i   (trap_epc_i),
        .mret_i       (mret_i),
        .irq_ext_i    (irq_ext_i),
        .irq_timer_i  (irq_timer_i),
        .irq_soft_i   (irq_soft_i),
        .hpm_event_i  (hpm_event_i),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .mstatus_o    (mstatus_o),
        .irq_req_o    (irq_req_o),
        .irq_cause_o  (irq_cause_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_op_i    = op;
        csr_addr_i  = addr;
        csr_wdata_i = wd;
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_tag.push_back(tag);
        exp_val.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] v;
        checks++;
        if (exp_val.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            tag = exp_tag.pop_front();
            v   = exp_val.pop_front();
            assert (obs === v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, v);
            end
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] v);
        drive(2'b00, addr, 32'h0);
        expect_v(tag, v);
        check(csr_rdata_o);
    endtask

    task automatic op_chk(input string tag, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
        drive(op, addr, wd);
        expect_v({tag, "_rdata"}, exp_rd);
        check(csr_rdata_o);
        expect_v({tag, "_illegal"}, {31'b0, exp_ill});
        check({31'b0, csr_illegal_o});
    endtask

    initial begin
        rst = 1'b0;
        csr_op_i = 2'b00; csr_addr_i = '0; csr_wdata_i = '0;
        retire_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
        trap_cause_i = '0; trap_epc_i = '0;
        irq_ext_i = 1'b0; irq_timer_i = 1'b0; irq_soft_i = 1'b0;
        hpm_event_i = '0;
        step(); step();
        rst = 1'b1;
        step();

        // Reset state
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mtvec",   12'h305, TB_MTVEC);
        rd("rst_mhartid", 12'hF14, TB_HARTID);
        expect_v("rst_irq_req", 32'h0);
        check({31'b0, irq_req_o});
        expect_v("rst_irq_cause", 32'h0);
        check(irq_cause_o);

        // mstatus set/clear/write with WARL masking
        op_chk("rs_mstatus", 2'b10, 12'h300, 32'h8, 32'h0000_1800, 1'b0);
        step();
        op_chk("rc_mstatus", 2'b11, 12'h300, 32'h8, 32'h0000_1808, 1'b0);
        step();
        op_chk("rw_mstatus", 2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0);
        step();
        rd("mstatus_warl", 12'h300, 32'h0000_1888);

        // mtvec mode bits: 11 rejected, 01 accepted
        op_chk("mtvec_bad_mode", 2'b01, 12'h305, 32'h2000_0003, TB_MTVEC, 1'b0);
        step();
        op_chk("mtvec_good_mode", 2'b01, 12'h305, 32'h0000_3001, 32'h2000_0000, 1'b0);
        step();
        rd("mtvec_read", 12'h305, 32'h0000_3001);
        expect_v("mtvec_o", 32'h0000_3001);
        check(mtvec_o);

        // mcycle: write hi then lo, watch the carry
        drive(2'b01, 12'hB80, 32'h0);
        step();
        drive(2'b01, 12'hB00, 32'hFFFF_FFFF);
        step();
        rd("mcycle_lo_written", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_hi_written", 12'hB80, 32'h0);
        step(); step();
        rd("mcycle_lo_wrapped", 12'hB00, 32'h0000_0001);
        rd("mcycle_hi_carry",   12'hB80, 32'h0000_0001);
        rd("cycle_shadow_lo",   12'hC00, 32'h0000_0001);
        rd("cycle_shadow_hi",   12'hC80, 32'h0000_0001);
        op_chk("set_cy", 2'b10, 12'h320, 32'h1, 32'h0, 1'b0);
        step();
        drive(2'b00, 12'h0, 32'h0);
        step(); step(); step();
        rd("mcycle_frozen_lo", 12'hB00, 32'h0000_0002);
        rd("mcycle_frozen_hi", 12'hB80, 32'h0000_0001);

        // Read-only and unimplemented addresses
        op_chk("rw_cycle", 2'b01, 12'hC00, 32'h5, 32'h0000_0002, 1'b1);
        step();
        rd("cycle_unchanged", 12'hB00, 32'h0000_0002);
        op_chk("rs0_cycle", 2'b10, 12'hC00, 32'h0, 32'h0000_0002, 1'b0);
        op_chk("rs1_cycle", 2'b10, 12'hC00, 32'h1, 32'h0000_0002, 1'b1);
        op_chk("rw_mhartid", 2'b01, 12'hF14, 32'h0, TB_HARTID, 1'b1);
        op_chk("unimpl", 2'b10, 12'h7C0, 32'h0, 32'h0, 1'b1);
        op_chk("hpm3_legal", 2'b01, 12'hB03, 32'h55, 32'h0, 1'b0);
        drive(2'b00, 12'h0, 32'h0);

        // minstret counts retirements
        retire_i = 1'b1;
        step(); step(); step();
        retire_i = 1'b0;
        rd("minstret", 12'hB02, 32'h0000_0003);

        // mie WARL and interrupt priority
        drive(2'b01, 12'h304, 32'hFFFF_FFFF);
        step();
        op_chk("mie_warl", 2'b01, 12'h304, 32'h0000_0800, 32'h0000_0888, 1'b0);
        step();
        irq_ext_i = 1'b1;
        rd("mip_ext", 12'h344, 32'h0000_0800);
        step();
        expect_v("irq_req_ext", 32'h1);
        check({31'b0, irq_req_o});
        expect_v("irq_cause_ext", 32'h8000_000B);
        check(irq_cause_o);
        irq_timer_i = 1'b1;
        step();
        expect_v("irq_cause_ext_timer", 32'h8000_000B);
        check(irq_cause_o);
        drive(2'b10, 12'h304, 32'h0000_0088);
        step();
        drive(2'b00, 12'h0, 32'h0);
        irq_ext_i  = 1'b0;
        irq_soft_i = 1'b1;
        step();
        expect_v("irq_cause_soft", 32'h8000_0003);
        check(irq_cause_o);
        irq_soft_i = 1'b0;
        step();
        expect_v("irq_cause_timer", 32'h8000_0007);
        check(irq_cause_o);
        irq_ext_i = 1'b1;
        step();
        expect_v("irq_req_before_trap", 32'h1);
        check({31'b0, irq_req_o});

        // Trap entry beats a same-cycle ex write to mepc
        trap_i = 1'b1; trap_cause_i = 32'h2; trap_epc_i = 32'h0000_0106;
        op_chk("trap_ex_mepc", 2'b01, 12'h341, 32'h40, 32'h0, 1'b0);
        step();
        trap_i = 1'b0;
        rd("trap_mepc",    12'h341, 32'h0000_0104);
        rd("trap_mcause",  12'h342, 32'h0000_0002);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);
        expect_v("trap_mepc_o", 32'h0000_0104);
        check(mepc_o);
        step();
        expect_v("irq_req_after_trap", 32'h0);
        check({31'b0, irq_req_o});

        // mret restores MIE; a same-cycle mscratch write still commits
        mret_i = 1'b1;
        drive(2'b01, 12'h340, 32'hDEAD_BEEF);
        step();
        mret_i = 1'b0;
        rd("mret_mstatus",  12'h300, 32'h0000_1888);
        rd("mret_mscratch", 12'h340, 32'hDEAD_BEEF);
        expect_v("mret_mstatus_o", 32'h0000_1888);
        check(mstatus_o);

        // mret suppresses a same-cycle mcause write
        mret_i = 1'b1;
        drive(2'b01, 12'h342, 32'h77);
        step();
        mret_i = 1'b0;
        rd("mret_blocks_mcause", 12'h342, 32'h0000_0002);

        // trap and mret together: trap wins
        trap_i = 1'b1; mret_i = 1'b1;
        trap_cause_i = 32'h8000_000B; trap_epc_i = 32'h0000_0203;
        drive(2'b00, 12'h0, 32'h0);
        step();
        trap_i = 1'b0; mret_i = 1'b0;
        rd("both_mstatus", 12'h300, 32'h0000_1880);
        rd("both_mepc",    12'h341, 32'h0000_0200);
        rd("both_mcause",  12'h342, 32'h8000_000B);

        // Reset mid-write aborts the pending write
        drive(2'b01, 12'h340, 32'h0000_1234);
        rst = 1'b0;
        step();
        rst = 1'b1;
        rd("rst_mscratch",     12'h340, 32'h0);
        rd("rst_mstatus_again", 12'h300, 32'h0000_1800);
        expect_v("rst_irq_req_again", 32'h0);
        check({31'b0, irq_req_o});

        if (exp_val.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_val.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Parametrised machine-mode CSR file for the RV32I pipeline core; successor to the fixed six-register CSR block.
- Executes CSRRW/CSRRS/CSRRC read-modify-write atomically and applies per-register WARL write masks.
- Performs hardware trap-entry and mret stacking of mstatus, and holds 64-bit mcycle/minstret with an inhibit register.
- Raises a registered interrupt request to clint; sits beside ex (instruction access) and clint (trap sequencing).

Parameters:
- XLEN, 32, CSR data width; only 32 is supported.
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- MHARTID, 0, value returned for mhartid (0xF14, read-only).
- NUM_HPM, 2, number of mhpmcounter3..(3+NUM_HPM-1); range 1..8, used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- csr_op_i  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- csr_addr_i  in  12  CSR address from ex
- csr_wdata_i  in  32  rs1 value or zero-extended uimm
- csr_rdata_o  out  32  old value of the addressed CSR (combinational)
- csr_illegal_o  out  1  unimplemented address, or write to a read-only CSR (combinational)
- retire_i  in  1  one instruction retired this cycle
- trap_i  in  1  trap entry pulse from clint
- trap_cause_i  in  32  mcause value for the trap
- trap_epc_i  in  32  pc to save into mepc
- mret_i  in  1  mret commit pulse from clint
- irq_ext_i, irq_timer_i, irq_soft_i  in  1 each  level interrupt sources (MEIP, MTIP, MSIP)
- hpm_event_i  in  NUM_HPM  per-counter event strobes
- mtvec_o, mepc_o, mstatus_o  out  32 each  live register values to clint
- irq_req_o  out  1  registered interrupt request
- irq_cause_o  out  32  registered cause paired with irq_req_o

Behaviour:
- Reset values (async on rst low):
  - mstatus = 0x0000_1800 (MPP=11).
  - mtvec = MTVEC_RST.
  - mie, mepc, mcause, mscratch, mcountinhibit, all counters = 0.
  - irq_req_o = 0, irq_cause_o = 0.
- Write value new:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with wdata==0 perform no write, so no illegal flag for read-only CSRs.
- Writes commit at the next rising edge. csr_rdata_o always returns the pre-write value; there is no bypass.
- WARL masks:
  - mstatus: only bits 3 (MIE) and 7 (MPIE) are writable; MPP is hardwired to 11; all other bits read 0.
  - mie: only bits 3, 7, 11 are writable.
  - mtvec: bits[1:0] are accepted only as 00 or 01; any other value keeps the old mode bits.
  - mepc[1:0] forced to 0.
  - mcause and mscratch are fully writable.
  - mcountinhibit: bits 0 (CY) and 2 (IR) are writable.
- mip (0x344) is read-only: bit 11 = irq_ext_i, bit 7 = irq_timer_i, bit 3 = irq_soft_i.
- Read-only counter shadows: cycle/cycleh (0xC00/0xC80) and instret/instreth (0xC02/0xC82). Writes to them, mhartid or mip assert csr_illegal_o and are dropped.
- Counters:
  - mcycle (0xB00/0xB80) increments every cycle unless CY=1.
  - minstret (0xB02/0xB82) increments on retire_i unless IR=1.
  - Low-half overflow carries into the high half in the same cycle.
  - A CSR write to either half takes precedence over that cycle's increment; the other half still receives the write-free carry.
- Trap entry (trap_i):
  - mepc <= trap_epc_i & ~3, mcause <= trap_cause_i.
  - MPIE <= MIE, MIE <= 0.
- mret_i: MIE <= MPIE, MPIE <= 1.
- Simultaneous events:
  - trap_i and mret_i together: trap_i wins.
  - Either of them suppresses any same-cycle ex write to mstatus, mepc or mcause. Ex writes to other CSRs still commit.
- Interrupt request:
  - pend = mie & mip.
  - irq_req_o <= MIE & |pend, registered for 1-cycle latency.
  - Priority MEI (cause 0x8000_000B) > MSI (0x8000_0003) > MTI (0x8000_0007).
  - irq_req_o drops the cycle after trap_i, because MIE is cleared.
- Reset asserted mid-operation aborts any pending write; no partial commit.

Optional Feature:
- Macro CSR_HPM_COUNTER_EN.
- Defined:
  - NUM_HPM 64-bit mhpmcounterN/hN (0xB03+i/0xB83+i) and read-only shadows (0xC03+i/0xC83+i).
  - Counter i increments on hpm_event_i[i]; it is inhibited by mcountinhibit bit 3+i, which becomes writable.
- Undefined:
  - Those addresses read 0 and are legal; writes are ignored.
  - hpm_event_i is unused; mcountinhibit bits 3+ read 0.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams.
  - Write masks for mstatus, mie and mcountinhibit.
  - The csr_op_e enum.
  - Interrupt cause constants.
  - The mstatus bit indices.
- One sub-module, csr_counter64:
  - Behaviour: 64-bit counter with inc, inhibit, and lo/hi write ports.
  - Instantiated for mcycle, minstret and each HPM counter.

Test Plan:
- Reset, then read 0x300 / 0x305 / 0xF14 -> 0x0000_1800 / MTVEC_RST / MHARTID; irq_req_o = 0.
- CSRRS 0x300 with 0x8, then CSRRC 0x300 with 0x8 -> reads 0x1808, then 0x1800; CSRRW 0x300 with 0xFFFF_FFFF -> reads 0x1888.
- Write mcycle lo 0xFFFF_FFFF, hi 0 -> two cycles later hi = 1, lo = 0x0000_0001; set CY=1 -> value frozen.
- mie = 0x800, MIE = 1, irq_ext_i = 1 -> irq_req_o = 1 one cycle later with cause 0x8000_000B; with irq_timer_i also 1, the cause stays 0x8000_000B.
- trap_i with epc 0x0000_0106, cause 2, plus a same-cycle ex CSRRW of mepc = 0x40 -> mepc = 0x104, mcause = 2, MIE = 0, MPIE = 1; mret -> MIE = 1.
- CSRRW 0xC00 -> csr_illegal_o = 1, no change; CSRRS 0xC00 with 0 -> legal, returns the cycle count.
